usb1bd_pd: RTL and testbench
============================

# usb1bd_pd

Packet disassembler for the USB 1.1 device core; receive-side counterpart of the packet assembler. Consumes the UTMI RX byte stream, checks and decodes the PID, extracts token fields (address, endpoint, frame number), checks CRC5/CRC16, and forwards data-packet payload to the protocol engine / RX FIFO with the two trailing CRC bytes stripped. Sits between the UTMI line interface and the protocol engine.

## Interface
- No parameters.
- clk  in  1  core clock (UTMI byte clock domain)
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  UTMI received byte
- rx_valid  in  1  rx_data strobe
- rx_active  in  1  packet in progress
- rx_err  in  1  UTMI receive error (bit-stuff/EOP)
- pid_out, pid_in, pid_setup, pid_sof, pid_data0, pid_data1, pid_data2, pid_mdata, pid_ack, pid_nack, pid_stall, pid_nyet, pid_ping  out  1 each  decoded PID flags
- pid_cks_err  out  1  PID check nibble mismatch
- token_fadr  out  7  token function address
- token_endp  out  4  token endpoint
- frame_no  out  11  SOF frame number
- token_valid  out  1  one-cycle pulse, token complete and CRC5 good
- crc5_err  out  1  one-cycle pulse, token CRC5 bad
- rx_data_st  out  8  payload byte
- rx_data_valid  out  1  one-cycle payload strobe
- rx_data_done  out  1  one-cycle pulse at end of data packet
- crc16_err  out  1  one-cycle pulse with rx_data_done if CRC16 bad or packet short
- seq_err  out  1  one-cycle pulse: rx_err seen or rx_active dropped mid-token
- state  out  4  debug: one-hot FSM state

## Operation
- FSM one-hot: IDLE=0001, ACTIVE=0010 (await PID), TOKEN=0100, DATA=1000.
- IDLE -> ACTIVE on rx_active. ACTIVE, first rx_valid: latch PID byte; low nibble is PID, high nibble must equal its complement else pid_cks_err=1 and all PID flags 0.
- PID codes (low nibble): OUT 1, IN 9, SOF 5, SETUP D, PING 4, DATA0 3, DATA1 B, DATA2 7, MDATA F, ACK 2, NACK A, STALL E, NYET 6.
- After PID: token PIDs -> TOKEN; data PIDs -> DATA; handshake/invalid -> wait in ACTIVE for rx_active low, then IDLE.
- TOKEN: byte0 = fadr[6:0] + endp[0]; byte1 = endp[3:1] + crc5 in bits[7:3]. After byte1: run CRC5 over 16 received bits LSB-first; residual 5'b01100 -> token_valid, else crc5_err. Load token_fadr/token_endp (non-SOF) or frame_no = {byte1[2:0],byte0} (SOF). Bytes beyond byte1 ignored.
- DATA: CRC16 (init 16'hffff) updated on every byte, bit-reversed input as in TX path. Two-byte hold pipeline: a byte is emitted on rx_data_st/rx_data_valid only when a third later byte arrives, so the final two bytes (CRC) are never forwarded. On rx_active fall: rx_data_done; crc16_err if residual != 16'h800D or fewer than 2 bytes after PID.
- rx_err in any non-IDLE state: seq_err, abort to ACTIVE-drain (wait rx_active low), no token_valid/rx_data_done.
- rx_active falls in TOKEN before byte1: seq_err, no token_valid, -> IDLE.
- rx_active falling in same cycle as rx_valid: byte processed first, then end-of-packet handling.

## Timing
- Reset: state=IDLE, all flags/pulses 0, token_fadr=0, token_endp=0, frame_no=0, rx_data_st=0.
- PID flags/pid_cks_err registered: valid the cycle after the PID byte strobe; held until next PID latched.
- token_valid/crc5_err: cycle after byte1 strobe.
- rx_data_valid: cycle after strobe of byte N+2 carries byte N.
- rx_data_done/crc16_err: cycle after rx_active sampled low.
- Back-to-back packets with one idle cycle between rx_active assertions supported.

## Configuration
- USB1BD_PD_SOF_EN defined: SOF decoded, pid_sof asserted, frame_no updated, token_valid pulses for good SOF.
- Not defined: pid_sof tied 0, frame_no tied 0, SOF packets drained silently (no token_valid, no crc5_err); frame_no register not synthesized.

## Structure
- PID nibble constants (USB1BD_T_PID_*) and CRC residual constants live in usb1bd_defines.v, shared with TX path.
- Sub-module usb1bd_crc5 (11/16-bit CRC5 combinational); reuse existing usb1bd_crc16 for data.

## Test plan
- SETUP to addr 0 ep 0: 0x2D,0x00,0x10 -> pid_setup=1, token_valid pulse, fadr=0, endp=0, crc5_err=0.
- Same token with byte1 = 0x11 -> crc5_err pulse, no token_valid.
- DATA0 zero-length 0xC3,0x00,0x00 -> rx_data_done, no rx_data_valid, crc16_err=0.
- DATA1 0x4B + 8 payload bytes + bench-model CRC -> exactly 8 rx_data_valid strobes in order, crc16_err=0; flip one payload bit -> crc16_err=1.
- ACK 0xD2 -> pid_ack=1 one cycle later; 0xD3 -> pid_cks_err=1, all flags 0.
- rx_err after token byte0, and rx_active drop after byte0 -> seq_err pulse, no token_valid; SOF 0xA5 with SOF_EN off -> no outputs.

Source files
------------

// File: rtl/usb1bd_pd_pkg.sv
// rtl/usb1bd_pd_pkg.sv - PID codes, CRC constants and PID classification for the packet disassembler
package usb1bd_pd_pkg;

    localparam logic [3:0] USB1BD_T_PID_OUT   = 4'h1;
    localparam logic [3:0] USB1BD_T_PID_IN    = 4'h9;
    localparam logic [3:0] USB1BD_T_PID_SOF   = 4'h5;
    localparam logic [3:0] USB1BD_T_PID_SETUP = 4'hd;
    localparam logic [3:0] USB1BD_T_PID_PING  = 4'h4;
    localparam logic [3:0] USB1BD_T_PID_DATA0 = 4'h3;
    localparam logic [3:0] USB1BD_T_PID_DATA1 = 4'hb;
    localparam logic [3:0] USB1BD_T_PID_DATA2 = 4'h7;
    localparam logic [3:0] USB1BD_T_PID_MDATA = 4'hf;
    localparam logic [3:0] USB1BD_T_PID_ACK   = 4'h2;
    localparam logic [3:0] USB1BD_T_PID_NACK  = 4'ha;
    localparam logic [3:0] USB1BD_T_PID_STALL = 4'he;
    localparam logic [3:0] USB1BD_T_PID_NYET  = 4'h6;

    localparam logic [4:0]  USB1BD_CRC5_POLY      = 5'h05;
    localparam logic [4:0]  USB1BD_CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] USB1BD_CRC16_POLY     = 16'h8005;
    localparam logic [15:0] USB1BD_CRC16_RESIDUAL = 16'h800d;

    typedef enum logic [1:0] {
        PID_CLASS_TOKEN,
        PID_CLASS_DATA,
        PID_CLASS_OTHER
    } pid_class_t;

    // A PID byte whose check nibble is wrong falls into OTHER so it is drained.
    function automatic pid_class_t pid_class(input logic [7:0] pid_byte, input logic sof_en);
        pid_class_t cls;
        cls = PID_CLASS_OTHER;
        if (pid_byte[7:4] == ~pid_byte[3:0]) begin
            case (pid_byte[3:0])
                USB1BD_T_PID_OUT, USB1BD_T_PID_IN,
                USB1BD_T_PID_SETUP, USB1BD_T_PID_PING:     cls = PID_CLASS_TOKEN;
                USB1BD_T_PID_SOF:                          cls = sof_en ? PID_CLASS_TOKEN : PID_CLASS_OTHER;
                USB1BD_T_PID_DATA0, USB1BD_T_PID_DATA1,
                USB1BD_T_PID_DATA2, USB1BD_T_PID_MDATA:    cls = PID_CLASS_DATA;
                default:                                   cls = PID_CLASS_OTHER;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/usb1bd_crc16.sv
// rtl/usb1bd_crc16.sv - one-byte CRC16 update, byte consumed LSB first as on the wire
module usb1bd_crc16
    import usb1bd_pd_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  din,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = {crc_out[14:0], 1'b0} ^ ((din[i] ^ crc_out[15]) ? USB1BD_CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb1bd_crc5.sv
// rtl/usb1bd_crc5.sv - CRC5 residual over a 16-bit token body (11 data bits plus 5 CRC bits), LSB first
module usb1bd_crc5
    import usb1bd_pd_pkg::*;
(
    input  logic [15:0] din,
    output logic [4:0]  residual
);

    always_comb begin
        residual = 5'h1f;
        for (int i = 0; i < 16; i++) begin
            residual = {residual[3:0], 1'b0} ^ ((din[i] ^ residual[4]) ? USB1BD_CRC5_POLY : 5'h00);
        end
    end

endmodule

// File: rtl/usb1bd_pd.sv
// rtl/usb1bd_pd.sv - USB 1.1 receive packet disassembler; SOF decode enabled by USB1BD_PD_SOF_EN
module usb1bd_pd
    import usb1bd_pd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_err,
    output logic        pid_out,
    output logic        pid_in,
    output logic        pid_setup,
    output logic        pid_sof,
    output logic        pid_data0,
    output logic        pid_data1,
    output logic        pid_data2,
    output logic        pid_mdata,
    output logic        pid_ack,
    output logic        pid_nack,
    output logic        pid_stall,
    output logic        pid_nyet,
    output logic        pid_ping,
    output logic        pid_cks_err,
    output logic [6:0]  token_fadr,
    output logic [3:0]  token_endp,
    output logic [10:0] frame_no,
    output logic        token_valid,
    output logic        crc5_err,
    output logic [7:0]  rx_data_st,
    output logic        rx_data_valid,
    output logic        rx_data_done,
    output logic        crc16_err,
    output logic        seq_err,
    output logic [3:0]  state
);

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_ACTIVE = 4'b0010;
    localparam logic [3:0] ST_TOKEN  = 4'b0100;
    localparam logic [3:0] ST_DATA   = 4'b1000;

    logic [3:0]  pid_q;
    logic        pid_ok_q;
    logic        pid_seen;
    logic [1:0]  tok_cnt;
    logic [7:0]  tok0;
    logic [1:0]  data_cnt;
    logic [1:0]  data_cnt_upd;
    logic [7:0]  hold0;
    logic [7:0]  hold1;
    logic [15:0] crc16_q;
    logic [15:0] crc16_next;
    logic [15:0] crc16_upd;
    logic [4:0]  crc5_res;
    logic        pid_good;
    logic        tok_done;
    logic        tok_is_sof;
    pid_class_t  cls;

    assign pid_good = (rx_data[7:4] == ~rx_data[3:0]);
`ifdef USB1BD_PD_SOF_EN
    assign cls = pid_class(rx_data, 1'b1);
`else
    assign cls = pid_class(rx_data, 1'b0);
`endif

    usb1bd_crc5 u_crc5 (
        .din      ({rx_data, tok0}),
        .residual (crc5_res)
    );

    usb1bd_crc16 u_crc16 (
        .crc_in  (crc16_q),
        .din     (rx_data),
        .crc_out (crc16_next)
    );

    // End-of-packet decisions must see the byte strobed in the same cycle.
    assign crc16_upd    = rx_valid ? crc16_next : crc16_q;
    assign data_cnt_upd = (rx_valid && data_cnt != 2'd2) ? data_cnt + 2'd1 : data_cnt;
    assign tok_done     = (state == ST_TOKEN) && !rx_err && rx_valid && (tok_cnt == 2'd1);
    assign tok_is_sof   = (pid_q == USB1BD_T_PID_SOF);

    assign pid_out     = pid_ok_q && (pid_q == USB1BD_T_PID_OUT);
    assign pid_in      = pid_ok_q && (pid_q == USB1BD_T_PID_IN);
    assign pid_setup   = pid_ok_q && (pid_q == USB1BD_T_PID_SETUP);
    assign pid_data0   = pid_ok_q && (pid_q == USB1BD_T_PID_DATA0);
    assign pid_data1   = pid_ok_q && (pid_q == USB1BD_T_PID_DATA1);
    assign pid_data2   = pid_ok_q && (pid_q == USB1BD_T_PID_DATA2);
    assign pid_mdata   = pid_ok_q && (pid_q == USB1BD_T_PID_MDATA);
    assign pid_ack     = pid_ok_q && (pid_q == USB1BD_T_PID_ACK);
    assign pid_nack    = pid_ok_q && (pid_q == USB1BD_T_PID_NACK);
    assign pid_stall   = pid_ok_q && (pid_q == USB1BD_T_PID_STALL);
    assign pid_nyet    = pid_ok_q && (pid_q == USB1BD_T_PID_NYET);
    assign pid_ping    = pid_ok_q && (pid_q == USB1BD_T_PID_PING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pid_q         <= 4'h0;
            pid_ok_q      <= 1'b0;
            pid_cks_err   <= 1'b0;
            pid_seen      <= 1'b0;
            tok_cnt       <= 2'd0;
            tok0          <= 8'h00;
            data_cnt      <= 2'd0;
            hold0         <= 8'h00;
            hold1         <= 8'h00;
            crc16_q       <= 16'hffff;
            rx_data_st    <= 8'h00;
            token_valid   <= 1'b0;
            crc5_err      <= 1'b0;
            rx_data_valid <= 1'b0;
            rx_data_done  <= 1'b0;
            crc16_err     <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            token_valid   <= 1'b0;
            crc5_err      <= 1'b0;
            rx_data_valid <= 1'b0;
            rx_data_done  <= 1'b0;
            crc16_err     <= 1'b0;
            seq_err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_active) begin
                        state    <= ST_ACTIVE;
                        pid_seen <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (rx_err) begin
                        seq_err  <= 1'b1;
                        pid_seen <= 1'b1;
                        if (!rx_active) state <= ST_IDLE;
                    end else if (rx_valid && !pid_seen) begin
                        pid_q       <= rx_data[3:0];
                        pid_ok_q    <= pid_good;
                        pid_cks_err <= !pid_good;
                        pid_seen    <= 1'b1;
                        tok_cnt     <= 2'd0;
                        data_cnt    <= 2'd0;
                        crc16_q     <= 16'hffff;
                        case (cls)
                            PID_CLASS_TOKEN: begin
                                if (rx_active) state <= ST_TOKEN;
                                else begin
                                    seq_err <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end
                            PID_CLASS_DATA: begin
                                if (rx_active) state <= ST_DATA;
                                else begin
                                    rx_data_done <= 1'b1;
                                    crc16_err    <= 1'b1;
                                    state        <= ST_IDLE;
                                end
                            end
                            default: begin
                                if (!rx_active) state <= ST_IDLE;
                            end
                        endcase
                    end else if (!rx_active) begin
                        state <= ST_IDLE;
                    end
                end
                ST_TOKEN: begin
                    if (rx_err) begin
                        seq_err <= 1'b1;
                        state   <= rx_active ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        if (rx_valid && tok_cnt == 2'd0) begin
                            tok0    <= rx_data;
                            tok_cnt <= 2'd1;
                        end else if (tok_done) begin
                            tok_cnt     <= 2'd2;
                            token_valid <= (crc5_res == USB1BD_CRC5_RESIDUAL);
                            crc5_err    <= (crc5_res != USB1BD_CRC5_RESIDUAL);
                        end
                        if (!rx_active) begin
                            state <= ST_IDLE;
                            if (tok_cnt == 2'd0 || (tok_cnt == 2'd1 && !rx_valid)) seq_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_err) begin
                        seq_err <= 1'b1;
                        state   <= rx_active ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        // Two bytes are always held back so the CRC never reaches the FIFO.
                        if (rx_valid) begin
                            crc16_q  <= crc16_next;
                            data_cnt <= data_cnt_upd;
                            hold0    <= rx_data;
                            hold1    <= hold0;
                            if (data_cnt == 2'd2) begin
                                rx_data_st    <= hold1;
                                rx_data_valid <= 1'b1;
                            end
                        end
                        if (!rx_active) begin
                            state        <= ST_IDLE;
                            rx_data_done <= 1'b1;
                            crc16_err    <= (crc16_upd != USB1BD_CRC16_RESIDUAL) || (data_cnt_upd != 2'd2);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            token_fadr <= 7'h00;
            token_endp <= 4'h0;
        end else if (tok_done && !tok_is_sof) begin
            token_fadr <= tok0[6:0];
            token_endp <= {rx_data[2:0], tok0[7]};
        end
    end

`ifdef USB1BD_PD_SOF_EN
    logic [10:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= 11'h000;
        else if (tok_done && tok_is_sof) frame_q <= {rx_data[2:0], tok0};
    end

    assign frame_no = frame_q;
    assign pid_sof  = pid_ok_q && tok_is_sof;
`else
    assign frame_no = 11'h000;
    assign pid_sof  = 1'b0;
`endif

endmodule

// File: tb/tb_usb1bd_pd.sv
// tb/tb_usb1bd_pd.sv - self-checking bench for usb1bd_pd (default build, SOF decode off)
module tb_usb1bd_pd;

    typedef logic [7:0] bq_t[$];
    localparam int NCYC = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_active = 1'b0;
    logic        rx_err = 1'b0;
    logic        pid_out, pid_in, pid_setup, pid_sof, pid_data0, pid_data1, pid_data2;
    logic        pid_mdata, pid_ack, pid_nack, pid_stall, pid_nyet, pid_ping, pid_cks_err;
    logic [6:0]  token_fadr;
    logic [3:0]  token_endp;
    logic [10:0] frame_no;
    logic        token_valid, crc5_err, rx_data_valid, rx_data_done, crc16_err, seq_err;
    logic [7:0]  rx_data_st;
    logic [3:0]  state;
    logic [13:0] dut_flags;

    always #5 clk = ~clk;

    usb1bd_pd dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_active(rx_active), .rx_err(rx_err),
        .pid_out(pid_out), .pid_in(pid_in), .pid_setup(pid_setup), .pid_sof(pid_sof),
        .pid_data0(pid_data0), .pid_data1(pid_data1), .pid_data2(pid_data2),
        .pid_mdata(pid_mdata), .pid_ack(pid_ack), .pid_nack(pid_nack),
        .pid_stall(pid_stall), .pid_nyet(pid_nyet), .pid_ping(pid_ping),
        .pid_cks_err(pid_cks_err), .token_fadr(token_fadr), .token_endp(token_endp),
        .frame_no(frame_no), .token_valid(token_valid), .crc5_err(crc5_err),
        .rx_data_st(rx_data_st), .rx_data_valid(rx_data_valid), .rx_data_done(rx_data_done),
        .crc16_err(crc16_err), .seq_err(seq_err), .state(state)
    );

    assign dut_flags = {pid_cks_err, pid_out, pid_in, pid_setup, pid_sof, pid_data0, pid_data1,
                        pid_data2, pid_mdata, pid_ack, pid_nack, pid_stall, pid_nyet, pid_ping};

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    int tv_cnt = 0, c5_cnt = 0, dv_cnt = 0, dd_cnt = 0, c16_cnt = 0, seq_cnt = 0;

    // Expected timeline, indexed by the clock edge whose registered result is being observed.
    bit          e_tv[NCYC], e_c5[NCYC], e_dv[NCYC], e_dd[NCYC], e_c16[NCYC], e_seq[NCYC];
    logic [7:0]  e_dst[NCYC];
    bit          u_pid[NCYC], u_tok[NCYC];
    logic [13:0] u_flags[NCYC];
    logic [6:0]  u_fadr[NCYC];
    logic [3:0]  u_endp[NCYC];
    logic [13:0] cur_flags = 14'h0;
    logic [6:0]  cur_fadr = 7'h0;
    logic [3:0]  cur_endp = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // CRC5 field as it appears in token byte1[7:3].
    function automatic logic [4:0] crc5_field(input logic [10:0] d);
        logic [4:0] c = 5'h1f;
        logic [4:0] f;
        for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'h05 : 5'h00);
        for (int j = 0; j < 5; j++) f[j] = ~c[4-j];
        return f;
    endfunction

    // CRC16 trailer over the first n bytes of q: {first byte on wire, second byte}.
    function automatic logic [15:0] crc16_tx(input bq_t q, input int n);
        logic [15:0] c = 16'hffff;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) c = {c[14:0], 1'b0} ^ ((q[k][i] ^ c[15]) ? 16'h8005 : 16'h0);
        return {rev8(~c[15:8]), rev8(~c[7:0])};
    endfunction

    function automatic logic [13:0] flags_of(input logic [7:0] p);
        logic [12:0] f = '0;
        if (p[7:4] != ~p[3:0]) return 14'h2000;
        case (p[3:0])
            4'h1: f[12] = 1'b1;
            4'h9: f[11] = 1'b1;
            4'hd: f[10] = 1'b1;
            4'h3: f[8] = 1'b1;
            4'hb: f[7] = 1'b1;
            4'h7: f[6] = 1'b1;
            4'hf: f[5] = 1'b1;
            4'h2: f[4] = 1'b1;
            4'ha: f[3] = 1'b1;
            4'he: f[2] = 1'b1;
            4'h6: f[1] = 1'b1;
            4'h4: f[0] = 1'b1;
            default: f = '0;
        endcase
        return {1'b0, f};
    endfunction

    function automatic bq_t mk_tok11(input logic [7:0] pid, input logic [10:0] d);
        bq_t q;
        q.push_back(pid);
        q.push_back(d[7:0]);
        q.push_back({crc5_field(d), d[10:8]});
        return q;
    endfunction

    function automatic bq_t mk_data(input logic [7:0] pid, input bq_t pl);
        bq_t q;
        logic [15:0] c = crc16_tx(pl, pl.size());
        q.push_back(pid);
        foreach (pl[i]) q.push_back(pl[i]);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
        return q;
    endfunction

    task automatic step(input logic act, input logic val, input logic [7:0] d, input logic err);
        rx_active = act;
        rx_valid  = val;
        rx_data   = d;
        rx_err    = err;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // err_after < 0: whole packet then rx_active drop; otherwise send that many bytes, pulse rx_err, drop.
    task automatic run_packet(input bq_t pkt, input int err_after);
        int base = cyc;
        int nsent = (err_after >= 0) ? err_after : pkt.size();
        int drop_e = base + 2 + nsent + ((err_after >= 0) ? 1 : 0);
        if (nsent >= 1) begin
            logic [7:0] p = pkt[0];
            int m = nsent - 1;
            int pe = base + 2;
            bit good = (p[7:4] == ~p[3:0]);
            bit is_tok = good && (p[3:0] inside {4'h1, 4'h9, 4'hd, 4'h4});
            bit is_dat = good && (p[3:0] inside {4'h3, 4'hb, 4'h7, 4'hf});
            u_pid[pe] = 1'b1;
            u_flags[pe] = flags_of(p);
            if (is_tok) begin
                if (m >= 2) begin
                    bit ok = (crc5_field({pkt[2][2:0], pkt[1]}) == pkt[2][7:3]);
                    e_tv[pe+2] = ok;
                    e_c5[pe+2] = !ok;
                    u_tok[pe+2] = 1'b1;
                    u_fadr[pe+2] = pkt[1][6:0];
                    u_endp[pe+2] = {pkt[2][2:0], pkt[1][7]};
                end else if (err_after < 0) begin
                    e_seq[drop_e] = 1'b1;
                end
            end
            if (is_dat) begin
                for (int i = 0; i + 2 < m; i++) begin
                    e_dv[pe+3+i] = 1'b1;
                    e_dst[pe+3+i] = pkt[1+i];
                end
                if (err_after < 0) begin
                    e_dd[drop_e] = 1'b1;
                    if (m < 2) e_c16[drop_e] = 1'b1;
                    else begin
                        bq_t pl;
                        logic [15:0] c;
                        for (int i = 1; i <= m - 2; i++) pl.push_back(pkt[i]);
                        c = crc16_tx(pl, pl.size());
                        e_c16[drop_e] = !(pkt[m-1] == c[15:8] && pkt[m] == c[7:0]);
                    end
                end
            end
        end
        if (err_after >= 0) e_seq[base+2+nsent] = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < nsent; k++) step(1'b1, 1'b1, pkt[k], 1'b0);
        if (err_after >= 0) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_on && cyc < NCYC) begin
            if (u_pid[cyc]) cur_flags = u_flags[cyc];
            if (u_tok[cyc]) begin
                cur_fadr = u_fadr[cyc];
                cur_endp = u_endp[cyc];
            end
            check("token_valid", token_valid, e_tv[cyc]);
            check("crc5_err", crc5_err, e_c5[cyc]);
            check("rx_data_valid", rx_data_valid, e_dv[cyc]);
            check("rx_data_done", rx_data_done, e_dd[cyc]);
            check("crc16_err", crc16_err, e_c16[cyc]);
            check("seq_err", seq_err, e_seq[cyc]);
            check("pid_flags", dut_flags, cur_flags);
            check("token_fadr", token_fadr, cur_fadr);
            check("token_endp", token_endp, cur_endp);
            check("frame_no", frame_no, 11'h0);
            if (e_dv[cyc]) check("rx_data_st", rx_data_st, e_dst[cyc]);
            tv_cnt += token_valid;
            c5_cnt += crc5_err;
            dv_cnt += rx_data_valid;
            dd_cnt += rx_data_done;
            c16_cnt += crc16_err;
            seq_cnt += seq_err;
        end
    end

    initial begin
        bq_t q, pl;
        int t0, t1, t2, t3;
        logic [15:0] c;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_state", state, 4'b0001);
        check("reset_flags", dut_flags, 14'h0);
        check("reset_fadr_endp", {token_fadr, token_endp}, 11'h0);
        check("reset_rx_data_st", rx_data_st, 8'h00);
        check("reset_pulses", {token_valid, crc5_err, rx_data_valid, rx_data_done, crc16_err, seq_err}, 6'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk_on = 1'b1;

        check("model_crc5_zero_token", {crc5_field(11'h0), 3'b000}, 8'h10);
        pl = {};
        c = crc16_tx(pl, 0);
        check("model_crc16_empty", c, 16'h0000);

        // SETUP addr 0 ep 0
        t0 = tv_cnt; t1 = c5_cnt;
        q = '{8'h2d, 8'h00, 8'h10};
        run_packet(q, -1);
        check("setup_flag", pid_setup, 1'b1);
        check("setup_fadr", token_fadr, 7'h00);
        check("setup_token_valid_count", tv_cnt - t0, 1);
        check("setup_crc5_err_count", c5_cnt - t1, 0);

        // Corrupted CRC5
        t0 = tv_cnt; t1 = c5_cnt;
        q = '{8'h2d, 8'h00, 8'h11};
        run_packet(q, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("bad_crc5_token_valid_count", tv_cnt - t0, 0);
        check("bad_crc5_err_count", c5_cnt - t1, 1);

        // Non-zero address/endpoint tokens, back-to-back
        run_packet(mk_tok11(8'he1, {4'h5, 7'h3a}), -1);
        run_packet(mk_tok11(8'h69, {4'hf, 7'h7f}), -1);
        check("in_fadr", token_fadr, 7'h7f);
        run_packet(mk_tok11(8'hb4, {4'ha, 7'h01}), -1);

        // DATA0 zero length
        t0 = dd_cnt; t1 = dv_cnt; t2 = c16_cnt;
        q = '{8'hc3, 8'h00, 8'h00};
        run_packet(q, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("zlp_done_count", dd_cnt - t0, 1);
        check("zlp_valid_count", dv_cnt - t1, 0);
        check("zlp_crc16_err_count", c16_cnt - t2, 0);

        // DATA1 with 8 payload bytes, then same with one flipped bit
        pl = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef};
        q = mk_data(8'h4b, pl);
        t1 = dv_cnt; t2 = c16_cnt;
        run_packet(q, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("data1_strobe_count", dv_cnt - t1, 8);
        check("data1_last_byte", rx_data_st, 8'hef);
        check("data1_crc16_err_count", c16_cnt - t2, 0);
        q[4] = q[4] ^ 8'h10;
        t2 = c16_cnt;
        run_packet(q, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("flipped_crc16_err_count", c16_cnt - t2, 1);

        // Short data packet, MDATA with 3 payload bytes
        q = '{8'hc3, 8'haa};
        run_packet(q, -1);
        pl = '{8'h5a, 8'h00, 8'hff};
        run_packet(mk_data(8'h0f, pl), -1);

        // Handshakes and a bad PID check nibble
        q = '{8'hd2};
        run_packet(q, -1);
        check("ack_flag", pid_ack, 1'b1);
        q = '{8'hd3};
        run_packet(q, -1);
        check("cks_err_flag", pid_cks_err, 1'b1);
        check("cks_err_other_flags", dut_flags[12:0], 13'h0);

        // rx_err after token byte0, then rx_active drop after byte0
        t0 = tv_cnt; t3 = seq_cnt;
        q = '{8'h2d, 8'h00, 8'h10};
        run_packet(q, 2);
        q = '{8'h2d, 8'h00};
        run_packet(q, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("aborted_token_valid_count", tv_cnt - t0, 0);
        check("aborted_seq_err_count", seq_cnt - t3, 2);

        // SOF is drained silently when SOF decode is off
        t0 = tv_cnt; t1 = c5_cnt; t3 = seq_cnt;
        run_packet(mk_tok11(8'ha5, 11'h123), -1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("sof_no_pulses", (tv_cnt - t0) + (c5_cnt - t1) + (seq_cnt - t3), 0);
        check("sof_flags", dut_flags, 14'h0);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
